// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 message padder front end.
package sha256_pkg;

   localparam logic [255:0] SHA256_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [7:0] PAD_BYTE = 8'h80;

   typedef enum logic [1:0] {
      FILL,
      PAD,
      ISSUE,
      WAIT
   } state_t;

   // Byte counts 5..7 behave as a full word.
   function automatic logic [2:0] clamp_bytes(input logic [2:0] n);
      return (n > 3'd4) ? 3'd4 : n;
   endfunction

endpackage

// File: rtl/sha256_last_word.sv
// Final-word shaping: keeps the top n bytes, zeros the rest and inserts the
// 0x80 marker when it fits; flags a pending marker word when the word is full.
module sha256_last_word
   import sha256_pkg::*;
(
   input  logic [31:0] data,
   input  logic [2:0]  n,
   output logic [31:0] word,
   output logic        pad_pending
);

   logic [2:0] nb;

   always_comb begin
      nb   = clamp_bytes(n);
      word = '0;
      for (int unsigned b = 0; b < 4; b++) begin
         if (b < 32'(nb)) begin
            word[31-8*b -: 8] = data[31-8*b -: 8];
         end else if (b == 32'(nb)) begin
            word[31-8*b -: 8] = PAD_BYTE;
         end
      end
      pad_pending = (nb == 3'd4);
   end

endmodule

// File: rtl/sha256_msg_padder.sv
// Stream-to-block front end for a SHA-256 core: packs words, applies padding
// and the length field, chains digests between blocks and reports the hash.
module sha256_msg_padder
   import sha256_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_last,
   input  logic [2:0]            i_last_bytes,
   output logic                  o_ready,
   output logic [511:0]          o_block,
   output logic [255:0]          o_hash_in,
   output logic                  o_load,
   input  logic [255:0]          i_digest,
   input  logic                  i_digest_valid,
   output logic [255:0]          o_digest,
   output logic                  o_done
);

   state_t       state, state_nxt;
   logic [31:0]  blk [16];
   logic [3:0]   wcnt;
   logic [63:0]  bitlen;
   logic         pad_pending, len_pending, len_in_blk;
   logic [255:0] chain;
   logic [31:0]  lw_word, pad_word;
   logic         lw_pad, accept;
   logic [2:0]   nb;

   sha256_last_word u_last_word (
      .data        (i_data),
      .n           (i_last_bytes),
      .word        (lw_word),
      .pad_pending (lw_pad)
   );

   assign accept    = (state == FILL) && i_valid;
   assign nb        = clamp_bytes(i_last_bytes);
   assign o_ready   = (state == FILL);
   assign o_load    = (state == ISSUE);
   assign o_hash_in = chain;

   always_comb begin
      o_block = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         o_block[511-32*i -: 32] = blk[i];
      end
   end

   // len_pending means the length field belongs to the following block.
   always_comb begin
      pad_word = '0;
      if (pad_pending) begin
         pad_word = {PAD_BYTE, 24'h0};
      end else if (!len_pending && wcnt == 4'd14) begin
         pad_word = bitlen[63:32];
      end else if (!len_pending && wcnt == 4'd15) begin
         pad_word = bitlen[31:0];
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL: begin
            if (accept) begin
               if (wcnt == 4'd15) begin
                  state_nxt = ISSUE;
               end else if (i_last) begin
                  state_nxt = PAD;
               end
            end
         end
         PAD: begin
            if (wcnt == 4'd15) state_nxt = ISSUE;
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (i_digest_valid) begin
               if (len_in_blk) begin
                  state_nxt = FILL;
               end else if (pad_pending || len_pending) begin
                  state_nxt = PAD;
               end else begin
                  state_nxt = FILL;
               end
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 16; i++) blk[i] <= '0;
         wcnt        <= '0;
         bitlen      <= '0;
         pad_pending <= 1'b0;
         len_pending <= 1'b0;
         len_in_blk  <= 1'b0;
         chain       <= SHA256_IV;
         o_digest    <= '0;
         o_done      <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            FILL: begin
               if (accept) begin
                  blk[wcnt] <= i_last ? lw_word : i_data;
                  wcnt      <= wcnt + 4'd1;
                  if (i_last) begin
                     bitlen      <= bitlen + {58'd0, nb, 3'd0};
                     pad_pending <= lw_pad;
                     len_pending <= !lw_pad && (wcnt >= 4'd14);
                  end else begin
                     bitlen <= bitlen + 64'd32;
                  end
               end
            end
            PAD: begin
               blk[wcnt]   <= pad_word;
               wcnt        <= wcnt + 4'd1;
               pad_pending <= 1'b0;
               if (pad_pending && wcnt >= 4'd14) len_pending <= 1'b1;
               if (!pad_pending && !len_pending && wcnt == 4'd15) len_in_blk <= 1'b1;
            end
            WAIT: begin
               if (i_digest_valid) begin
                  if (len_in_blk) begin
                     o_digest   <= i_digest;
                     o_done     <= 1'b1;
                     chain      <= SHA256_IV;
                     bitlen     <= '0;
                     len_in_blk <= 1'b0;
                  end else begin
                     chain       <= i_digest;
                     len_pending <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: byte-level padding reference,
// randomized stream and core-side timing, directed boundary messages.
module tb_sha256_msg_padder;
   import sha256_pkg::*;

   typedef logic [7:0] byte_q_t[$];

   localparam logic [255:0] ABC_DIG =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_valid, i_last, i_digest_valid;
   logic [31:0]  i_data;
   logic [2:0]   i_last_bytes;
   logic         o_ready, o_load, o_done;
   logic [511:0] o_block;
   logic [255:0] o_hash_in, i_digest, o_digest;

   int unsigned  total = 0;
   int unsigned  bad = 0;
   logic [255:0] held_dig = '0;
   int           msgs = 0;

   logic [31:0]  wq_data[$];
   logic         wq_last[$];
   logic [2:0]   wq_n[$];
   int           wq_lat[$];
   logic [511:0] bq_blk[$];
   logic [255:0] bq_dig[$];
   bit           bq_final[$];

   sha256_msg_padder #(.DATA_WIDTH(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_valid        (i_valid),
      .i_data         (i_data),
      .i_last         (i_last),
      .i_last_bytes   (i_last_bytes),
      .o_ready        (o_ready),
      .o_block        (o_block),
      .o_hash_in      (o_hash_in),
      .o_load         (o_load),
      .i_digest       (i_digest),
      .i_digest_valid (i_digest_valid),
      .o_digest       (o_digest),
      .o_done         (o_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic byte_q_t rand_bytes(input int n);
      byte_q_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ready"}, o_ready, 1'b1);
      chk({tag, "_load"}, o_load, 1'b0);
      chk({tag, "_done"}, o_done, 1'b0);
      chk({tag, "_block"}, o_block, '0);
      chk({tag, "_digest"}, o_digest, '0);
      chk({tag, "_hash_in"}, o_hash_in, SHA256_IV);
   endtask

   // Reference: words as a host would send them, blocks from the FIPS byte-level padding rule.
   task automatic add_message(input byte_q_t m, input logic [255:0] final_dig, input bit fixed_dig);
      byte_q_t     p;
      int          len, nw, nb, k, nblk;
      logic [31:0] d;
      logic [63:0] bits;
      logic [511:0] blk;
      len = m.size();
      nw  = (len == 0) ? 1 : (len + 3) / 4;
      for (int w = 0; w < nw; w++) begin
         d  = $urandom;
         nb = (w == nw - 1) ? len - 4 * w : 4;
         for (int b = 0; b < nb; b++) d[31-8*b -: 8] = m[4*w+b];
         wq_data.push_back(d);
         wq_last.push_back(w == nw - 1);
         if (w == nw - 1) begin
            k = w % 16;
            wq_n.push_back((nb == 4) ? 3'($urandom_range(4, 7)) : 3'(nb));
            wq_lat.push_back((nb < 4 && k < 14) ? 16 - k : -1);
         end else begin
            wq_n.push_back(3'($urandom));
            wq_lat.push_back(-1);
         end
      end
      p = m;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      bits = 64'(len) * 64'd8;
      for (int b = 0; b < 8; b++) p.push_back(bits[63-8*b -: 8]);
      nblk = p.size() / 64;
      for (int j = 0; j < nblk; j++) begin
         for (int b = 0; b < 64; b++) blk[511-8*b -: 8] = p[64*j+b];
         bq_blk.push_back(blk);
         bq_final.push_back(j == nblk - 1);
         bq_dig.push_back((fixed_dig && j == nblk - 1) ? final_dig : rand256());
      end
      msgs++;
   endtask

   task automatic run_stream(input int budget);
      int           cyc = 0, wi = 0, acc_cyc = 0, dly = 0, loads = 0, dones = 0;
      int           exp_load_cyc = -1, dv_cyc = -1;
      int           nwords, nblk, nmsg;
      bit           acc = 0, outstanding = 0, done_exp = 0, cur_final = 0, hold;
      logic [511:0] cur_blk = '0;
      logic [255:0] cur_dig = '0, done_dig = '0;
      logic [255:0] chain = SHA256_IV;
      nwords = wq_data.size();
      nblk   = bq_blk.size();
      nmsg   = msgs;
      while (!(wi == nwords && loads == nblk && dones == nmsg && !outstanding && !done_exp)) begin
         @(negedge clk);
         cyc++;
         if (cyc > budget) break;
         if (acc) begin
            if (wq_lat[wi] >= 0) exp_load_cyc = acc_cyc + wq_lat[wi];
            wi++;
         end
         if (o_load) begin
            chk("load_when_expected", (bq_blk.size() > 0) && !outstanding, 1'b1);
            if (bq_blk.size() > 0 && !outstanding) begin
               cur_blk   = bq_blk.pop_front();
               cur_dig   = bq_dig.pop_front();
               cur_final = bq_final.pop_front();
               chk("block", o_block, cur_blk);
               chk("hash_in", o_hash_in, chain);
               if (exp_load_cyc >= 0) begin
                  chk("load_latency", cyc, exp_load_cyc);
                  exp_load_cyc = -1;
               end
               outstanding = 1;
               dly = $urandom_range(1, 6);
               loads++;
            end
         end else if (outstanding) begin
            chk("ready_in_wait", o_ready, 1'b0);
            chk("block_hold", o_block, cur_blk);
            chk("hash_hold", o_hash_in, chain);
         end
         if (done_exp && cyc == dv_cyc + 1) begin
            chk("done_pulse", o_done, 1'b1);
            chk("digest", o_digest, done_dig);
            chk("ready_at_done", o_ready, 1'b1);
            held_dig = done_dig;
            done_exp = 0;
            dones++;
         end else begin
            chk("no_done", o_done, 1'b0);
            chk("digest_held", o_digest, held_dig);
         end
         i_digest_valid = 1'b0;
         i_digest       = rand256();
         if (outstanding) begin
            if (dly == 0) begin
               i_digest_valid = 1'b1;
               i_digest       = cur_dig;
               outstanding    = 0;
               dv_cyc         = cyc;
               chain          = cur_final ? SHA256_IV : cur_dig;
               if (cur_final) begin
                  done_exp = 1;
                  done_dig = cur_dig;
               end
            end else begin
               dly--;
            end
         end else if (!o_load && $urandom_range(0, 9) == 0) begin
            i_digest_valid = 1'b1;
         end
         hold = i_valid && !acc;
         if (!hold) begin
            if (wi < nwords && $urandom_range(0, 3) != 0) begin
               i_valid      = 1'b1;
               i_data       = wq_data[wi];
               i_last       = wq_last[wi];
               i_last_bytes = wq_n[wi];
            end else begin
               i_valid      = 1'b0;
               i_data       = $urandom;
               i_last       = 1'($urandom);
               i_last_bytes = 3'($urandom);
            end
         end
         acc     = i_valid && o_ready;
         acc_cyc = cyc;
      end
      i_valid        = 1'b0;
      i_last         = 1'b0;
      i_digest_valid = 1'b0;
      chk("words_sent", wi, nwords);
      chk("load_count", loads, nblk);
      chk("done_count", dones, nmsg);
      wq_data.delete(); wq_last.delete(); wq_n.delete(); wq_lat.delete();
      bq_blk.delete(); bq_dig.delete(); bq_final.delete();
      msgs = 0;
   endtask

   initial begin
      byte_q_t m;
      int      lens[6];
      i_valid = 1'b0; i_data = '0; i_last = 1'b0; i_last_bytes = '0;
      i_digest = '0; i_digest_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;

      m = {8'h61, 8'h62, 8'h63};
      add_message(m, ABC_DIG, 1'b1);
      run_stream(400);

      m = {};
      add_message(m, '0, 1'b0);
      run_stream(400);

      m = rand_bytes(56);
      add_message(m, '0, 1'b0);
      run_stream(600);

      m = rand_bytes(64);
      add_message(m, '0, 1'b0);
      m = {8'h61, 8'h62, 8'h63};
      add_message(m, ABC_DIG, 1'b1);
      run_stream(900);

      lens = '{55, 59, 60, 63, $urandom_range(0, 140), $urandom_range(0, 140)};
      foreach (lens[i]) begin
         m = rand_bytes(lens[i]);
         add_message(m, '0, 1'b0);
      end
      run_stream(4000);

      // abort a short message while it is being padded
      @(negedge clk);
      i_valid = 1'b1; i_data = 32'h68656c6c; i_last = 1'b0; i_last_bytes = 3'd0;
      chk("pre_ready", o_ready, 1'b1);
      @(negedge clk);
      i_data = 32'h6f55aa11; i_last = 1'b1; i_last_bytes = 3'd1;
      @(negedge clk);
      i_valid = 1'b0; i_last = 1'b0;
      chk("pad_ready_low", o_ready, 1'b0);
      repeat (4) begin
         @(negedge clk);
         chk("no_load_before_reset", o_load, 1'b0);
      end
      #2 rst_n = 1'b0;
      #1 check_reset_vals("reset_mid_pad");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      held_dig = '0;
      repeat (20) begin
         @(negedge clk);
         chk("no_load_after_reset", o_load, 1'b0);
         chk("no_done_after_reset", o_done, 1'b0);
      end

      m = {8'h61, 8'h62, 8'h63};
      add_message(m, ABC_DIG, 1'b1);
      run_stream(400);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Front end that turns a 32-bit big-endian byte stream into padded 512-bit SHA-256 blocks and drives the compression core's load side. It applies FIPS 180-4 padding, including the 0x80 byte, zero fill and the 64-bit length field. It supplies the chaining value for each block: the IV for a new message, otherwise the previous digest. It captures the core's digest after each block and presents the final hash. It sits between the host/stream interface and the SHA-256 core, driving the core's message words, initial-hash inputs and load strobe.

## Interface
- DATA_WIDTH, 32, word width; only 32 supported
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  input word valid
- i_data  in  32  message word; first byte in [31:24]
- i_last  in  1  word is the final word of the message
- i_last_bytes  in  3  valid bytes in the last word, 0..4; values 5..7 are treated as 4; ignored unless i_last
- o_ready  out  1  word accepted when i_valid && o_ready
- o_block  out  512  message words 0..15, word 0 at [511:480]
- o_hash_in  out  256  chaining value H0..H7, H0 at [255:224]
- o_load  out  1  one-cycle strobe: o_block/o_hash_in are valid for the core
- i_digest  in  256  core output, H0 at [255:224]
- i_digest_valid  in  1  core finished the block just loaded
- o_digest  out  256  final message hash, held until the next final digest
- o_done  out  1  one-cycle pulse when o_digest updates

## Operation
- States: FILL, PAD, ISSUE, WAIT.
- FILL: o_ready=1. Each accepted word is written to word index wcnt (4-bit), then wcnt increments.
  - Non-last word: bitlen += 32.
  - Last word with n = i_last_bytes: keep the top n bytes, zero the rest, bitlen += 8n.
  - If n<4, place 0x80 in byte n of the same word.
  - If n=4, set pad_pending; the next word (0x80000000) is written in PAD.
- After the 16th word is written (wcnt wraps to 0) go to ISSUE; otherwise, if last, go to PAD.
- PAD: o_ready=0. One word per cycle: the pending 0x80 word, then zeros up to index 13, then bitlen[63:32] at 14 and bitlen[31:0] at 15, then ISSUE.
  - If 0x80 lands at index 14 or 15, zero-fill to 15 and ISSUE with len_pending set.
  - The following block is zeros 0..13 plus the length in 14..15.
- ISSUE: o_load=1 for exactly one cycle, then WAIT.
- WAIT: o_ready=0. On i_digest_valid, chain <= i_digest.
  - If the block just sent held the length: o_digest <= i_digest, o_done pulses, chain <= IV, bitlen <= 0, go to FILL.
  - Else if padding or length is still pending: go to PAD.
  - Else: go to FILL.
- bitlen is 64-bit unsigned and wraps mod 2^64.
- o_hash_in = chain register; it equals the IV at the start of every message.
- i_digest_valid outside WAIT is ignored. i_valid outside FILL is not accepted.

## Timing
- Reset values:
  - o_ready=1, o_load=0, o_done=0.
  - o_block=0, o_digest=0, o_hash_in=IV.
  - state=FILL, wcnt=0, bitlen=0, pad/len pending=0.
- Reset asserted mid-operation aborts the message immediately. No o_load or o_done is produced for it.
- Input handshake: standard valid/ready; i_data must be held while i_valid && !o_ready.
- Full block: 16th word accepted in cycle T -> o_load in T+1 -> o_ready=0 from T+1 until the cycle after i_digest_valid.
- Last word at index k<14 (n<4): PAD occupies T+1..T+(15-k), o_load at T+(16-k).
- o_done is asserted in the cycle after i_digest_valid of the final block. The next message may start that same cycle (o_ready=1).
- o_block and o_hash_in remain stable from o_load until i_digest_valid.

## Structure
- Package sha256_pkg: SHA256_IV (eight 32-bit constants 6a09e667 .. 5be0cd19), state enum, PAD_BYTE = 8'h80.
- Sub-module sha256_last_word: combinational byte mask and 0x80 insertion from (data, n), returning word plus pad_pending.
- The block register, counters and FSM stay in the top.

## Test plan
- "abc": i_data=0x61626300, last, n=3.
  - Required: single o_load with word0=0x61626380, words 1..14=0, word15=0x00000018, o_hash_in=IV.
  - Drive i_digest=ba7816bf…f20015ad -> o_done with that o_digest.
- Empty message: one word, last, n=0.
  - Required: word0=0x80000000, words 1..15=0, one o_load.
- 56-byte message (14 full words, last n=4).
  - Required: block 1 has words 14..15 = 0x80000000, 0. Block 2 is zeros with word15=0x000001C0.
  - Block 2's o_hash_in equals block 1's digest; o_done only after block 2.
- 64-byte message (16 words, last n=4).
  - Required: block 2 word0=0x80000000, word15=0x00000200.
  - o_ready stays 0 in WAIT with i_valid held high; no word is dropped or duplicated.
- Reset during PAD of a message.
  - Required: no o_load; all outputs at reset values.
  - The next "abc" message produces the correct hash with IV chaining.
